rr_mux_reg: RTL and testbench
=============================

Name: rr_mux_reg

Overview:
- Parametrised, registered N:1 channel multiplexer. Successor to the team's fixed 4-bit 2:1 combinational mux.
- Each of NUM_IN producers presents WIDTH-bit data with a valid/ready handshake.
- The block arbitrates between requesting channels (round-robin or fixed priority) and holds the winner in a one-entry output register.
- The output register also has a valid/ready handshake. Used wherever several datapath sources share one downstream consumer.

Parameters:
- WIDTH, 4, data width in bits (>=1).
- NUM_IN, 4, number of input channels (2..16).
- SEL_W, 2, width of the channel index; must equal ceil(log2(NUM_IN)).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel request.
- in_ready  output  NUM_IN  per-channel accept; at most one bit high per cycle.
- chan_en  input  NUM_IN  per-channel enable mask; a disabled channel is never granted.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  out_data/out_sel hold a word.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Reset: asserting rst_n low immediately forces:
  - out_valid=0, out_data=0, out_sel=0;
  - round-robin pointer ptr=0;
  - in_ready=0 (combinationally follows from the empty register and the reset state).
- Reset mid-transfer discards the held word; no handshake completes in that cycle.
- Request vector: req = in_valid & chan_en.
- load = !out_valid | out_ready. The register can take a word this cycle.
- Grant, combinational:
  - ARB_MODE=1: lowest set index of req.
  - ARB_MODE=0: first set bit of req searching ptr, ptr+1, ..., NUM_IN-1, 0, ..., ptr-1.
  - grant is one-hot or zero.
- in_ready = grant when load=1, else all-zero. in_ready may depend combinationally on in_valid, chan_en and out_ready.
- Transfer on channel i: in_valid[i] & in_ready[i] at a rising edge. Next cycle:
  - out_data = in_data[i];
  - out_sel = i;
  - out_valid = 1.
- Latency: input accepted in cycle N appears on the outputs in cycle N+1.
- Pointer update (ARB_MODE=0 only): on a transfer from channel i, ptr <= (i+1) mod NUM_IN. Otherwise ptr holds. In ARB_MODE=1, ptr stays 0.
- Output consumption:
  - out_valid & out_ready with no new transfer: out_valid <= 0. out_data/out_sel hold their last values.
  - Simultaneous consume and transfer: the register is reloaded in the same cycle and out_valid stays 1. Full throughput is one word per cycle.
- Stall: out_valid=1 & out_ready=0 gives load=0 and all in_ready=0. out_data/out_sel/out_valid are stable until consumed.
- No requests: grant=0, no transfer, ptr holds.
- chan_en change: takes effect in the same cycle. A held output word is unaffected.
- Fairness (round-robin): with all channels continuously requesting and out_ready=1, grants cycle 0,1,...,NUM_IN-1,0. No channel waits more than NUM_IN-1 transfers.
- Wrap-around: after a grant to NUM_IN-1, ptr=0.
- Inputs must hold in_data stable while in_valid=1 and not accepted. The block does not check this.

Test Plan (WIDTH=4, NUM_IN=4 unless noted):
- Reset: rst_n low mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 immediately. After release, first grant goes to channel 0 when all request.
- Single channel: in_valid=4'b0100, ch2 data=4'hA, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=4'hA, out_sel=2, out_valid=1. Next cycle out_valid=0.
- Round-robin: in_valid=4'b1111, data ch0..3 = 1,2,3,4, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3, one word per cycle, including the ptr wrap to 0.
- Backpressure: all channels requesting, out_ready=0 for 3 cycles after the first load -> in_ready=0 throughout; out_data=1, out_sel=0 stable. Raising out_ready gives ch1's word (2) the next cycle.
- Mask and fixed priority: ARB_MODE=1, in_valid=4'b1110, chan_en=4'b1011 -> grants ch1 repeatedly, ch2 never. Set chan_en=4'b1001 -> grants ch3.
- Idle/holes: ARB_MODE=0, ptr=3, in_valid=4'b0010 -> ch1 granted, ptr becomes 2. Then in_valid=0 -> no transfer, ptr stays 2, out_valid drops after consumption.

Source files
------------

// File: rtl/rr_mux_reg.sv
// Registered N:1 channel multiplexer with a valid/ready handshake on every channel and on the output.
// Arbitration is round-robin (ARB_MODE=0) or fixed priority with the lowest index winning (ARB_MODE=1).
module rr_mux_reg #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned NUM_IN   = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned ARB_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [NUM_IN-1:0]       chan_en,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [NUM_IN-1:0]   req;
  logic [NUM_IN-1:0]   grant;
  logic [2*NUM_IN-1:0] rot;
  logic                load;
  logic                found;
  logic                xfer;
  logic [SEL_W-1:0]    base;
  logic [SEL_W-1:0]    win_sel;
  logic [WIDTH-1:0]    win_data;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0]    out_data_q;
  logic [SEL_W-1:0]    out_sel_q;
  logic                out_valid_q;

  assign req  = in_valid & chan_en;
  assign load = !out_valid_q || out_ready;
  assign base = (ARB_MODE == 1) ? '0 : ptr_q;

  // Rotate the request vector so the search always starts at bit 0, then map back.
  always_comb begin
    rot     = {req, req} >> base;
    found   = 1'b0;
    win_sel = '0;
    for (int unsigned j = 0; j < NUM_IN; j++) begin
      if (!found && rot[j]) begin
        found   = 1'b1;
        win_sel = SEL_W'((32'(base) + j) % NUM_IN);
      end
    end
  end

  always_comb begin
    grant    = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (found && (win_sel == SEL_W'(i))) begin
        grant[i] = 1'b1;
        win_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Gating with rst_n keeps any handshake from completing while reset is held.
  assign in_ready = (rst_n && load) ? grant : '0;
  assign xfer     = |in_ready;
  assign ptr_d    = (win_sel == SEL_W'(NUM_IN - 1)) ? '0 : win_sel + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= win_data;
        out_sel_q   <= win_sel;
        if (ARB_MODE == 0) begin
          ptr_q <= ptr_d;
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Bench for rr_mux_reg: a round-robin and a fixed-priority instance share the same stimulus and are
// compared every cycle against a queue-free behavioural model, plus directed constant checks.
module tb_rr_mux_reg;
  localparam int W  = 4;
  localparam int N  = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    chan_en;
  logic            out_ready;
  logic [N-1:0]    rdy_rr, rdy_fp;
  logic [W-1:0]    od_rr, od_fp;
  logic [SW-1:0]   os_rr, os_fp;
  logic            ov_rr, ov_fp;

  int checks = 0;
  int errors = 0;

  // Model state per instance: index 0 = round-robin, 1 = fixed priority.
  int m_ptr[2];
  int m_v[2];
  int m_d[2];
  int m_s[2];
  int m_g[2];

  always #5 clk = ~clk;

  rr_mux_reg #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .ARB_MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_rr),
    .chan_en(chan_en), .out_data(od_rr), .out_sel(os_rr), .out_valid(ov_rr), .out_ready(out_ready)
  );

  rr_mux_reg #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .ARB_MODE(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_fp),
    .chan_en(chan_en), .out_data(od_fp), .out_sel(os_fp), .out_valid(ov_fp), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ptr[m] = 0; m_v[m] = 0; m_d[m] = 0; m_s[m] = 0; m_g[m] = -1;
    end
  endtask

  function automatic int model_grant(input int m);
    logic [N-1:0] req;
    int start;
    int idx;
    req = in_valid & chan_en;
    if (m_v[m] != 0 && !out_ready) return -1;
    start = (m == 1) ? 0 : m_ptr[m];
    for (int k = 0; k < N; k++) begin
      idx = (start + k) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int onehot(input int g);
    return (g < 0) ? 0 : (1 << g);
  endfunction

  task automatic chk_outputs();
    chk("out_valid_rr", 32'(ov_rr), 32'(m_v[0]));
    chk("out_data_rr",  32'(od_rr), 32'(m_d[0]));
    chk("out_sel_rr",   32'(os_rr), 32'(m_s[0]));
    chk("out_valid_fp", 32'(ov_fp), 32'(m_v[1]));
    chk("out_data_fp",  32'(od_fp), 32'(m_d[1]));
    chk("out_sel_fp",   32'(os_fp), 32'(m_s[1]));
  endtask

  // Called just after a falling edge with inputs already driven; returns on the next falling edge.
  task automatic cycle();
    #1;
    for (int m = 0; m < 2; m++) m_g[m] = model_grant(m);
    chk("in_ready_rr", 32'(rdy_rr), 32'(onehot(m_g[0])));
    chk("in_ready_fp", 32'(rdy_fp), 32'(onehot(m_g[1])));
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (m_g[m] >= 0) begin
        m_v[m] = 1;
        m_d[m] = int'((in_data >> (m_g[m] * W)) & 16'h000F);
        m_s[m] = m_g[m];
        if (m == 0) m_ptr[m] = (m_g[m] + 1) % N;
      end else if (out_ready) begin
        m_v[m] = 0;
      end
    end
    chk_outputs();
    @(negedge clk);
  endtask

  // Asynchronous reset pulse asserted between edges; outputs must clear without a clock.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(ov_rr), 32'd0);
    chk("rst_out_data",  32'(od_rr), 32'd0);
    chk("rst_out_sel",   32'(os_rr), 32'd0);
    chk("rst_in_ready",  32'(rdy_rr), 32'd0);
    chk("rst_in_ready_fp", 32'(rdy_fp), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    chan_en   = '1;
    out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk_outputs();
    chk("reset_in_ready", 32'(rdy_rr), 32'd0);
    rst_n = 1'b1;

    // Single channel request on ch2.
    in_valid = 4'b0100;
    in_data  = 16'h0A00;
    cycle();
    chk("single_data", 32'(od_rr), 32'hA);
    chk("single_sel",  32'(os_rr), 32'd2);
    in_valid = '0;
    cycle();
    chk("single_drain", 32'(ov_rr), 32'd0);

    // Pointer now 3; ch1 alone wins via wrap, pointer moves to 2.
    in_valid = 4'b0010;
    in_data  = 16'h0050;
    cycle();
    chk("hole_sel", 32'(os_rr), 32'd1);
    in_valid = '0;
    cycle();
    chk("hole_idle", 32'(ov_rr), 32'd0);
    in_valid = 4'b1111;
    in_data  = 16'h4321;
    cycle();
    chk("hole_ptr2", 32'(os_rr), 32'd2);

    // Reset mid-stream with a held word, then first grant after release goes to ch0.
    async_reset();
    cycle();
    chk("post_rst_sel", 32'(os_rr), 32'd0);

    // Round-robin fairness over two full rotations.
    async_reset();
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("rr_sel",   32'(os_rr), 32'(i % 4));
      chk("rr_data",  32'(od_rr), 32'(i % 4 + 1));
      chk("rr_valid", 32'(ov_rr), 32'd1);
    end

    // Backpressure: hold the first word for three cycles.
    async_reset();
    cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_in_ready", 32'(rdy_rr), 32'd0);
      chk("bp_data", 32'(od_rr), 32'd1);
      chk("bp_sel",  32'(os_rr), 32'd0);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_release_data", 32'(od_rr), 32'd2);
    chk("bp_release_sel",  32'(os_rr), 32'd1);

    // Mask and fixed priority.
    in_valid = 4'b1110;
    chan_en  = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("fp_mask_sel", 32'(os_fp), 32'd1);
    end
    chan_en = 4'b1001;
    cycle();
    chk("fp_mask_ch3", 32'(os_fp), 32'd3);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom());
      chan_en   = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'b1111;
      in_data   = 16'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
